rv32_lsu_mem: RTL
=================

Name: rv32_lsu_mem

Overview:
- Parametrised successor to the single-cycle word-only data memory.
- Multi-cycle load/store unit with integrated data RAM, sitting in the MEM stage of the pipelined RV32I core.
- Supports all RV32I access sizes: LB/LH/LW/LBU/LHU/SB/SH/SW, with byte lanes, sign/zero extension and misalignment detection.
- Models configurable memory latency through a valid/ready handshake. The pipeline stalls on req_ready=0.

Parameters:
- DEPTH_WORDS, 2048, RAM depth in 32-bit words (power of two, >=4).
- WAIT_CYCLES, 2, extra access latency in cycles (0..15).
- INIT_FILE, "", hex file loaded into RAM at time 0; empty string means no load.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 size/sign code.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2), taken from the low bytes.
- rsp_valid  out  1  one-cycle pulse, access complete.
- rsp_rdata  out  32  extended load data; 0 for stores/errors.
- rsp_err  out  1  misaligned or illegal funct3, qualified by rsp_valid.
- busy  out  1  state != IDLE.
- stat_loads  out  32  see Optional Feature.
- stat_stores  out  32  see Optional Feature.
- stat_errs  out  32  see Optional Feature.

Behaviour:
- Reset, async on rst=1:
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; stat_* = 0.
  - RAM contents are not cleared.
- FSM states IDLE, WAIT, ACCESS, RESP:
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata. Go to RESP if the request is an error; else go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 and decrements; go to ACCESS when counter==0.
  - ACCESS: perform the RAM operation in a single cycle; latch the result; go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; go to IDLE. A new request is accepted the cycle after RESP, never in RESP itself.
- Latency: accept edge at cycle 0; rsp_valid is high in cycle WAIT_CYCLES+2 for a good access and in cycle 1 for an error.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is an error.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Violation is an error.
- Error handling: no RAM write; rsp_rdata=0; rsp_err=1.
- Word index is addr[$clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Store byte enables:
  - SB: lane addr[1:0] takes wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} take wdata[15:0].
  - SW: all four lanes.
  - Unselected bytes are preserved.
- Load extraction:
  - Selected byte/half is shifted down to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW returns the word unchanged.
- rsp_rdata holds its value until the next RESP.
- Inputs are ignored outside IDLE; no queuing.
- Reset mid-operation (WAIT or ACCESS not yet completed): the pending store is discarded with no partial write; no response is issued.

Optional Feature:
- Macro LSU_STATS_EN.
- Defined:
  - stat_loads increments on each completed good load.
  - stat_stores increments on each completed good store.
  - stat_errs increments on each error response.
  - All three are 32-bit, saturate at 0xFFFF_FFFF, and update on the RESP cycle.
- Undefined: the stat_* ports remain present and are tied to 0; no counter flops are synthesised.

Test Plan:
- SW addr=0x100 data=0xDEADBEEF, then LW 0x100, WAIT_CYCLES=2 -> rsp_valid in cycle 4 after each accept; rdata=0xDEADBEEF; err=0.
- After the above, SB addr=0x101 data=0x55, then LW 0x100 -> 0xDEAD55EF. LB 0x103 -> 0xFFFFFFDE. LBU 0x103 -> 0x000000DE.
- SH addr=0x102 data=0x8001, then LH 0x102 -> 0xFFFF8001. LHU 0x102 -> 0x00008001. LW 0x100 -> 0x800155EF.
- LW addr=0x102, SH addr=0x105, and a load with funct3=011 -> each gives rsp_valid in cycle 1 with err=1 and rdata=0. A following LW 0x104 shows its prior contents unchanged.
- With DEPTH_WORDS=2048: SW addr=0x2000 data=0x12345678, then LW 0x0 -> 0x12345678 (wrap). With WAIT_CYCLES=0, rsp_valid is in cycle 2.
- SW 0x200 data=1 accepted, rst asserted in WAIT; after release, LW 0x200 -> old value (no write). With LSU_STATS_EN, stat_errs=0 after reset and stat_loads=1 after the load.

Source files
------------

// File: rtl/rv32_lsu_mem.sv
// rv32_lsu_mem: multi-cycle RV32I load/store unit with integrated data RAM and a valid/ready handshake.
// Optional LSU_STATS_EN macro enables saturating load/store/error counters.
module rv32_lsu_mem #(
  parameter int    DEPTH_WORDS = 2048,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3;
  localparam logic [3:0] WC1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [1:0]    state_q, state_d;
  logic          we_q, err_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q, rdata_q;
  logic [3:0]    cnt_q;
  logic          accept, bad_f3, mis, req_err;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word, sh, ld, wd;
  logic [3:0]    be;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];
  assign accept  = state_q == S_IDLE && req_valid;
  assign bad_f3  = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
  assign mis     = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_err = bad_f3 || mis;

  assign idx  = addr_q[AW+1:2];
  assign lane = addr_q[1:0];
  assign word = mem[idx];
  assign sh   = word >> {lane, 3'b000};

  always_comb begin
    ld = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
         f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : word;
    be = f3_q[1:0] == 2'b00 ? 4'b0001 << lane :
         f3_q[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
         f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    state_d = state_q == S_IDLE   ? (req_valid ? (req_err ? S_RESP : (WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS)) : S_IDLE) :
              state_q == S_WAIT   ? (cnt_q == 4'd0 ? S_ACCESS : S_WAIT) :
              state_q == S_ACCESS ? S_RESP : S_IDLE;
  end

  // Writes happen only in ACCESS, so a reset during WAIT leaves the RAM untouched.
  always_ff @(posedge clk)
    if (state_q == S_ACCESS && we_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        cnt_q   <= WC1;
        err_q   <= req_err;
        if (req_err) rdata_q <= '0;
      end
      if (state_q == S_WAIT) cnt_q <= cnt_q - 4'd1;
      if (state_q == S_ACCESS) rdata_q <= we_q ? '0 : ld;
    end
  end

  assign req_ready = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

`ifdef LSU_STATS_EN
  logic [31:0] loads_q, stores_q, errs_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (state_q == S_RESP) begin
      if (err_q && ~&errs_q) errs_q <= errs_q + 32'd1;
      if (!err_q && we_q && ~&stores_q) stores_q <= stores_q + 32'd1;
      if (!err_q && !we_q && ~&loads_q) loads_q <= loads_q + 32'd1;
    end
  end
  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errs   = '0;
`endif
endmodule
